// File: rtl/uart_packet_tx_pkg.sv
// Shared definitions for the packetising UART transmitter: FSM encoding,
// CRC-8 polynomial, frame widths and the byte-wide CRC helper.
package uart_packet_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_LOAD,
    ST_CRCLD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = 3;
  localparam int COUNT_W   = 10;

  // MSB-first CRC-8 over one whole byte, no reflection and no output xor.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < DATA_BITS; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_packet_tx_crc8_step.sv
// Combinational CRC-8 update that folds one full data byte into the running CRC.
module uart_packet_tx_crc8_step
  import uart_packet_tx_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  always_comb begin
    crc_o = crc8_byte(crc_i, data_i);
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Pops bytes from the FIFO, sends them as UART frames and appends a CRC-8 byte
// after every PKT_LEN data bytes.
module uart_packet_tx
  import uart_packet_tx_pkg::*;
#(
  parameter int          PKT_LEN      = 512,
  parameter int          CLKS_PER_BIT = 1,
  parameter int          PARITY_EN    = 0,
  parameter logic [7:0]  CRC_INIT     = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic               fifo_busy,
  input  logic [7:0]         fifo_data,
  output logic               fifo_re,
  output logic               tx,
  output logic               busy,
  output logic               isFinish,
  output logic [COUNT_W-1:0] byte_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e              state_q, state_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic [7:0]             crc_q, crc_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   crc_pending_q, crc_pending_d;
  logic                   is_crc_q, is_crc_d;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic                   isfinish_q, isfinish_d;

  logic [7:0] crc_next;
  logic       baud_last;
  logic       start_ok;

  uart_packet_tx_crc8_step u_crc8_step (
    .crc_i  (crc_q),
    .data_i (fifo_data),
    .crc_o  (crc_next)
  );

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign start_ok  = enable && !fifo_empty && !fifo_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= 8'h00;
      parity_q      <= 1'b0;
      crc_q         <= CRC_INIT;
      count_q       <= '0;
      crc_pending_q <= 1'b0;
      is_crc_q      <= 1'b0;
      bit_q         <= '0;
      baud_q        <= '0;
      isfinish_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      parity_q      <= parity_d;
      crc_q         <= crc_d;
      count_q       <= count_d;
      crc_pending_q <= crc_pending_d;
      is_crc_q      <= is_crc_d;
      bit_q         <= bit_d;
      baud_q        <= baud_d;
      isfinish_q    <= isfinish_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    parity_d      = parity_q;
    crc_d         = crc_q;
    count_d       = count_q;
    crc_pending_d = crc_pending_q;
    is_crc_d      = is_crc_q;
    bit_d         = bit_q;
    baud_d        = baud_q;
    isfinish_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && crc_pending_q) begin
          state_d = ST_CRCLD;
        end else if (start_ok) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!fifo_busy) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        shreg_d  = fifo_data;
        parity_d = ^fifo_data;
        crc_d    = crc_next;
        is_crc_d = 1'b0;
        baud_d   = '0;
        state_d  = ST_START;
      end

      ST_CRCLD: begin
        shreg_d       = crc_q;
        parity_d      = ^crc_q;
        is_crc_d      = 1'b1;
        crc_pending_d = 1'b0;
        baud_d        = '0;
        state_d       = ST_START;
      end

      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_IDX_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (is_crc_q) begin
            isfinish_d = 1'b1;
            crc_d      = CRC_INIT;
            count_d    = '0;
            is_crc_d   = 1'b0;
          end else if (count_q == COUNT_W'(PKT_LEN - 1)) begin
            count_d       = '0;
            crc_pending_d = 1'b1;
          end else begin
            count_d = count_q + COUNT_W'(1);
          end
          // Skipping IDLE here keeps the inter-frame gap within three cycles.
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (crc_pending_d) begin
            state_d = ST_CRCLD;
          end else if (start_ok) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg_q[0];
      ST_PARITY: tx = parity_q;
      default:   tx = 1'b1;
    endcase
  end

  assign fifo_re    = (state_q == ST_REQ);
  assign busy       = (state_q != ST_IDLE);
  assign isFinish   = isfinish_q;
  assign byte_count = count_q;

endmodule
